prince_sbox_cms_compress: RTL



---
 rtl/prince_cms_pkg.sv | 13 +
 rtl/cms_ring_refresh.sv | 18 +
 rtl/prince_sbox_cms_compress.sv | 111 +++++++++++
 3 files changed

// File: rtl/prince_cms_pkg.sv
// Shared types and share indexing for the CMS PRINCE S-box compression stage.
package prince_cms_pkg;

    localparam int NCOMP = 8;

    typedef logic [31:0] comp_vec_t;
    typedef logic [3:0]  nib_sh_t;

    function automatic int idx(input int b, input int s);
        return b * NCOMP + s;
    endfunction

endpackage

// File: rtl/cms_ring_refresh.sv
// Ring refresh of one output bit's component shares; each mask bit is used
// twice, so the XOR over all shares is unchanged.
module cms_ring_refresh
    import prince_cms_pkg::*;
(
    input  logic [NCOMP-1:0] comp,
    input  logic [NCOMP-1:0] mask,
    output logic [NCOMP-1:0] refreshed
);

    always_comb begin
        refreshed = '0;
        for (int s = 0; s < NCOMP; s++) begin
            refreshed[s] = comp[s] ^ mask[s] ^ mask[(s + NCOMP - 1) % NCOMP];
        end
    end

endmodule

// File: rtl/prince_sbox_cms_compress.sv
// Registered refresh (glitch barrier) and 8-to-2 share compression behind the
// CMS PRINCE S-box component functions, with a nibble-serial layer counter.
module prince_sbox_cms_compress
    import prince_cms_pkg::*;
#(
    parameter int NIBBLES = 16,
    parameter int NCOMP   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        layer_start_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] comp_i,
    input  logic [31:0] rand_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [3:0]  out_sh0_o,
    output logic [3:0]  out_sh1_o,
    output logic [3:0]  nibble_idx_o,
    output logic        layer_done_o
);

    comp_vec_t  refreshed;
    comp_vec_t  r_p1;
    logic       vld_p1;
    logic       vld_p2;
    nib_sh_t    sh0_p2;
    nib_sh_t    sh1_p2;
    logic       load_p1;
    logic       load_p2;
    logic       out_hs;
    logic       last_nibble;
    logic [3:0] count;

    function automatic nib_sh_t half_xor(input comp_vec_t r, input int lo);
        nib_sh_t h;
        h = '0;
        for (int b = 0; b < 4; b++) begin
            h[b] = ^r[idx(b, lo) +: 4];
        end
        return h;
    endfunction

    for (genvar b = 0; b < 4; b++) begin : g_refresh
        cms_ring_refresh u_refresh (
            .comp      (comp_i[idx(b, 0) +: NCOMP]),
            .mask      (rand_i[idx(b, 0) +: NCOMP]),
            .refreshed (refreshed[idx(b, 0) +: NCOMP])
        );
    end

    assign load_p2    = vld_p1 && (!vld_p2 || out_ready_i);
    assign in_ready_o = !vld_p1 || load_p2;
    assign load_p1    = in_valid_i && in_ready_o;

    // Stage 1: refreshed shares, the glitch barrier
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (load_p1) begin
            vld_p1 <= 1'b1;
        end else if (load_p2) begin
            vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (load_p1) begin
            r_p1 <= refreshed;
        end
    end

    // Stage 2: compressed output shares
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2 <= 1'b0;
            sh0_p2 <= '0;
            sh1_p2 <= '0;
        end else begin
            if (load_p2) begin
                vld_p2 <= 1'b1;
                sh0_p2 <= half_xor(r_p1, 0);
                sh1_p2 <= half_xor(r_p1, 4);
            end else if (out_ready_i) begin
                vld_p2 <= 1'b0;
            end
        end
    end

    assign out_valid_o = vld_p2;
    assign out_sh0_o   = sh0_p2;
    assign out_sh1_o   = sh1_p2;

    assign out_hs      = vld_p2 && out_ready_i;
    assign last_nibble = (count == 4'(NIBBLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (layer_start_i) begin
            count <= '0;
        end else if (out_hs) begin
            count <= last_nibble ? 4'd0 : count + 4'd1;
        end
    end

    assign nibble_idx_o = count;
    assign layer_done_o = out_hs && last_nibble && !layer_start_i;

endmodule
